// File: rtl/msx_slot_initiator.sv
// msx_slot_initiator: host-side MSX slot bus-cycle generator.
// Turns single read/write commands into Z80-timed memory or I/O cycles.
//
// Ports:
//   clk42m, reset_n        system clock, async active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_write, cmd_ioreq   cycle kind: write/read, I/O/memory
//   cmd_address, cmd_wdata cycle address and write data
//   rdata, rdata_en        last read byte and its update pulse
//   timeout                pulse when WAIT holds a cycle too long
//   p_slot_*               slot strobes, address, data bus halves
//   p_slot_wait, p_slot_int async cartridge inputs
//   int_n                  synchronized, inverted interrupt
`timescale 1ns/1ps

module msx_slot_initiator #(
    parameter int T_CLKS     = 12,
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk42m,
    input  logic        reset_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_ioreq,
    input  logic [15:0] cmd_address,
    input  logic [7:0]  cmd_wdata,

    output logic [7:0]  rdata,
    output logic        rdata_en,
    output logic        timeout,

    output logic        p_slot_sltsl_n,
    output logic        p_slot_mreq_n,
    output logic        p_slot_ioreq_n,
    output logic        p_slot_rd_n,
    output logic        p_slot_wr_n,
    output logic        p_slot_m1_n,
    output logic        p_slot_rfsh_n,
    output logic [15:0] p_slot_address,
    output logic [7:0]  p_slot_data_out,
    output logic        p_slot_data_oe,
    input  logic [7:0]  p_slot_data_in,
    input  logic        p_slot_wait,
    input  logic        p_slot_int,
    output logic        int_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TW,
        S_T3
    } state_t;

    localparam int PW = $clog2(T_CLKS);

    // Outputs are registered, so an event "at ph = k" is written on
    // the edge that moves ph from k-1 to k.  PH_PRE is that edge for
    // the T-state midpoint; PH_LAST closes the T-state.
    localparam logic [PW-1:0] PH_LAST = PW'(T_CLKS - 1);
    localparam logic [PW-1:0] PH_PRE  = PW'(T_CLKS / 2 - 1);
    localparam logic [7:0]    TW_MAX  = 8'(WAIT_LIMIT);

    state_t        state;
    logic [PW-1:0] ph;
    logic [7:0]    tw_cnt;
    logic [7:0]    tw_next;
    logic          cur_write;
    logic          cur_ioreq;

    logic          wait_meta;
    logic          wait_s;
    logic          int_meta;
    logic          int_s;

    logic          at_last;
    logic          sample;
    logic          abort;

    // Both async inputs get a plain 2-FF synchronizer.
    always_ff @(posedge clk42m or negedge reset_n) begin
        if (!reset_n) begin
            wait_meta <= 1'b0;
            wait_s    <= 1'b0;
            int_meta  <= 1'b0;
            int_s     <= 1'b0;
        end else begin
            wait_meta <= p_slot_wait;
            wait_s    <= wait_meta;
            int_meta  <= p_slot_int;
            int_s     <= int_meta;
        end
    end

    assign int_n         = ~int_s;
    assign p_slot_m1_n   = 1'b1;
    assign p_slot_rfsh_n = 1'b1;

    assign at_last = (ph == PH_LAST);

    // WAIT is looked at only at the end of memory T2 and of every TW.
    // The automatic TW of an I/O cycle is not wait-induced, so I/O T2
    // never samples.
    assign sample = at_last &&
                    ((state == S_T2 && !cur_ioreq) || state == S_TW);

    assign abort  = sample && wait_s && (tw_cnt >= TW_MAX);

    assign tw_next = (tw_cnt == 8'hFF) ? tw_cnt : tw_cnt + 8'd1;

    always_ff @(posedge clk42m or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            ph              <= '0;
            tw_cnt          <= 8'd0;
            cur_write       <= 1'b0;
            cur_ioreq       <= 1'b0;
            cmd_ready       <= 1'b1;
            rdata           <= 8'd0;
            rdata_en        <= 1'b0;
            timeout         <= 1'b0;
            p_slot_sltsl_n  <= 1'b1;
            p_slot_mreq_n   <= 1'b1;
            p_slot_ioreq_n  <= 1'b1;
            p_slot_rd_n     <= 1'b1;
            p_slot_wr_n     <= 1'b1;
            p_slot_address  <= 16'd0;
            p_slot_data_out <= 8'd0;
            p_slot_data_oe  <= 1'b0;
        end else begin
            rdata_en <= 1'b0;
            timeout  <= 1'b0;

            if (abort) begin
                // Give up: release the bus in one step.
                state          <= S_IDLE;
                ph             <= '0;
                cmd_ready      <= 1'b1;
                timeout        <= 1'b1;
                p_slot_sltsl_n <= 1'b1;
                p_slot_mreq_n  <= 1'b1;
                p_slot_ioreq_n <= 1'b1;
                p_slot_rd_n    <= 1'b1;
                p_slot_wr_n    <= 1'b1;
                p_slot_data_oe <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        // cmd_ready is high throughout IDLE.
                        if (cmd_valid) begin
                            state          <= S_T1;
                            ph             <= '0;
                            tw_cnt         <= 8'd0;
                            cmd_ready      <= 1'b0;
                            cur_write      <= cmd_write;
                            cur_ioreq      <= cmd_ioreq;
                            p_slot_address <= cmd_address;
                            if (cmd_write) begin
                                p_slot_data_out <= cmd_wdata;
                                p_slot_data_oe  <= 1'b1;
                            end
                        end
                    end

                    S_T1: begin
                        ph <= ph + 1'b1;
                        if (ph == PH_PRE && !cur_ioreq) begin
                            p_slot_mreq_n  <= 1'b0;
                            p_slot_sltsl_n <= 1'b0;
                            if (!cur_write) begin
                                p_slot_rd_n <= 1'b0;
                            end
                        end
                        if (at_last) begin
                            state <= S_T2;
                            ph    <= '0;
                            if (cur_ioreq) begin
                                p_slot_ioreq_n <= 1'b0;
                                if (cur_write) begin
                                    p_slot_wr_n <= 1'b0;
                                end else begin
                                    p_slot_rd_n <= 1'b0;
                                end
                            end
                        end
                    end

                    S_T2: begin
                        ph <= ph + 1'b1;
                        if (ph == PH_PRE && !cur_ioreq && cur_write) begin
                            p_slot_wr_n <= 1'b0;
                        end
                        if (at_last) begin
                            ph <= '0;
                            if (cur_ioreq) begin
                                state <= S_TW;
                            end else if (wait_s) begin
                                state  <= S_TW;
                                tw_cnt <= tw_next;
                            end else begin
                                state <= S_T3;
                            end
                        end
                    end

                    S_TW: begin
                        ph <= ph + 1'b1;
                        if (at_last) begin
                            ph <= '0;
                            if (wait_s) begin
                                tw_cnt <= tw_next;
                            end else begin
                                state <= S_T3;
                            end
                        end
                    end

                    S_T3: begin
                        ph <= ph + 1'b1;
                        // Capture on the same edge that releases the
                        // strobes, while RD_n is still low.
                        if (ph == PH_PRE) begin
                            if (!cur_write) begin
                                rdata    <= p_slot_data_in;
                                rdata_en <= 1'b1;
                            end
                            p_slot_sltsl_n <= 1'b1;
                            p_slot_mreq_n  <= 1'b1;
                            p_slot_ioreq_n <= 1'b1;
                            p_slot_rd_n    <= 1'b1;
                            p_slot_wr_n    <= 1'b1;
                        end
                        if (at_last) begin
                            state          <= S_IDLE;
                            ph             <= '0;
                            cmd_ready      <= 1'b1;
                            p_slot_data_oe <= 1'b0;
                        end
                    end

                    default: begin
                        state     <= S_IDLE;
                        ph        <= '0;
                        cmd_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msx_slot_initiator.sv
// tb_msx_slot_initiator: scoreboard bench for msx_slot_initiator.
// Cycle n below is the clock period that follows edge n-1; the accept edge is edge 0.
`timescale 1ns/1ps

module tb_msx_slot_initiator;

    localparam int T   = 12;
    localparam int LIM = 4;

    logic        clk42m = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_ioreq;
    logic [15:0] cmd_address;
    logic [7:0]  cmd_wdata;
    logic [7:0]  rdata;
    logic        rdata_en;
    logic        timeout;
    logic        p_slot_sltsl_n;
    logic        p_slot_mreq_n;
    logic        p_slot_ioreq_n;
    logic        p_slot_rd_n;
    logic        p_slot_wr_n;
    logic        p_slot_m1_n;
    logic        p_slot_rfsh_n;
    logic [15:0] p_slot_address;
    logic [7:0]  p_slot_data_out;
    logic        p_slot_data_oe;
    logic [7:0]  p_slot_data_in;
    logic        p_slot_wait;
    logic        p_slot_int;
    logic        int_n;

    always #5 clk42m = ~clk42m;

    msx_slot_initiator #(.T_CLKS(T), .WAIT_LIMIT(LIM)) dut (
        .clk42m          (clk42m),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_ioreq       (cmd_ioreq),
        .cmd_address     (cmd_address),
        .cmd_wdata       (cmd_wdata),
        .rdata           (rdata),
        .rdata_en        (rdata_en),
        .timeout         (timeout),
        .p_slot_sltsl_n  (p_slot_sltsl_n),
        .p_slot_mreq_n   (p_slot_mreq_n),
        .p_slot_ioreq_n  (p_slot_ioreq_n),
        .p_slot_rd_n     (p_slot_rd_n),
        .p_slot_wr_n     (p_slot_wr_n),
        .p_slot_m1_n     (p_slot_m1_n),
        .p_slot_rfsh_n   (p_slot_rfsh_n),
        .p_slot_address  (p_slot_address),
        .p_slot_data_out (p_slot_data_out),
        .p_slot_data_oe  (p_slot_data_oe),
        .p_slot_data_in  (p_slot_data_in),
        .p_slot_wait     (p_slot_wait),
        .p_slot_int      (p_slot_int),
        .int_n           (int_n)
    );

    // Cartridge contents: 0x4000 holds 0xA5, the rest is a hash.
    function automatic logic [7:0] cart(input logic [15:0] a);
        if (a == 16'h4000) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign p_slot_data_in = cart(p_slot_address);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        bit          io;
        logic [15:0] addr;
        logic [7:0]  data;
        bit          tmo;
        int          idle_cyc;
        int          rden_cyc;
        int          strobe_lo;
        int          rw_lo;
        int          sl_lo;
        int          oe_hi;
    } exp_t;

    exp_t sbq[$];

    // Reference: a bus cycle is T1,T2,[TW...],T3 of T clocks each.
    // WAIT is high in cycles [ws,we); a decision at edge E sees the
    // level of cycle E-2 through the two synchronizer flops.
    function automatic exp_t model(input bit wr, input bit io,
                                   input logic [15:0] a,
                                   input logic [7:0] d,
                                   input int ws, input int we);
        exp_t e;
        int   first;
        int   ntw;
        int   ab;
        int   fall;
        int   rise;
        int   endq;
        int   ttw;
        bit   stop;
        first = io ? 3 * T : 2 * T;
        ntw   = 0;
        ab    = 0;
        stop  = 0;
        e.tmo = 0;
        for (int i = 0; i <= LIM && !stop; i++) begin
            int ee;
            ee = first + T * i;
            if (!((ee - 2) >= ws && (ee - 2) < we)) begin
                stop = 1;
            end else if (i == LIM) begin
                e.tmo = 1;
                ab    = ee;
                stop  = 1;
            end else begin
                ntw++;
            end
        end
        ttw  = ntw + (io ? 1 : 0);
        endq = e.tmo ? ab : (3 + ttw) * T;
        fall = io ? T : T / 2;
        rise = e.tmo ? ab : (2 + ttw) * T + T / 2;
        e.wr        = wr;
        e.io        = io;
        e.addr      = a;
        e.data      = wr ? d : cart(a);
        e.idle_cyc  = endq + 1;
        e.strobe_lo = rise - fall;
        e.rw_lo     = (wr && !io) ? rise - (T + T / 2) : rise - fall;
        e.sl_lo     = io ? 0 : rise - fall;
        e.oe_hi     = wr ? endq : 0;
        e.rden_cyc  = (!wr && !e.tmo) ? (2 + ttw) * T + T / 2 + 1 : 0;
        return e;
    endfunction

    // Monitor: integrates one bus cycle from the first busy cycle to
    // the return of cmd_ready, then checks it against the queue head.
    bit          mon_en = 0;
    bit          busy = 0;
    int          cyc, mreq_lo, io_lo, rd_lo, wr_lo, sl_lo, oe_hi;
    int          rden_n, rden_cyc, tmo_n;
    logic [7:0]  rdv, dout;
    logic [15:0] adr;

    task automatic finish_txn();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("queue_nonempty", 0, 1);
            return;
        end
        e = sbq.pop_front();
        chk("idle_cycle", cyc, e.idle_cyc);
        chk("cmd_strobe_lo", e.io ? io_lo : mreq_lo, e.strobe_lo);
        chk("other_strobe_lo", e.io ? mreq_lo : io_lo, 0);
        chk("rw_lo", e.wr ? wr_lo : rd_lo, e.rw_lo);
        chk("rw_other_lo", e.wr ? rd_lo : wr_lo, 0);
        chk("sltsl_lo", sl_lo, e.sl_lo);
        chk("oe_hi", oe_hi, e.oe_hi);
        chk("timeout_cnt", tmo_n, e.tmo);
        chk("rdata_en_cnt", rden_n, (e.rden_cyc != 0) ? 1 : 0);
        chk("address", adr, e.addr);
        if (e.rden_cyc != 0) begin
            chk("rdata_en_cycle", rden_cyc, e.rden_cyc);
            chk("rdata", rdv, e.data);
        end
        if (e.wr) chk("data_out", dout, e.data);
        chk("strobes_idle",
            {p_slot_sltsl_n, p_slot_mreq_n, p_slot_ioreq_n,
             p_slot_rd_n, p_slot_wr_n, p_slot_m1_n, p_slot_rfsh_n},
            7'h7F);
    endtask

    always @(negedge clk42m) begin
        if (!mon_en) begin
            busy = 0;
        end else begin
            if (busy) cyc++;
            if (!busy && !cmd_ready) begin
                busy = 1; cyc = 1;
                mreq_lo = 0; io_lo = 0; rd_lo = 0; wr_lo = 0;
                sl_lo = 0; oe_hi = 0; rden_n = 0; rden_cyc = 0;
                tmo_n = 0; rdv = 8'd0;
                adr = p_slot_address; dout = p_slot_data_out;
            end
            if (busy) begin
                if (rdata_en) begin
                    rden_n++; rden_cyc = cyc; rdv = rdata;
                end
                if (timeout) tmo_n++;
                if (cmd_ready && cyc > 1) begin
                    finish_txn();
                    busy = 0;
                end else begin
                    if (!p_slot_mreq_n)  mreq_lo++;
                    if (!p_slot_ioreq_n) io_lo++;
                    if (!p_slot_rd_n)    rd_lo++;
                    if (!p_slot_wr_n)    wr_lo++;
                    if (!p_slot_sltsl_n) sl_lo++;
                    if (p_slot_data_oe)  oe_hi++;
                end
            end
        end
    end

    // Issue one command from a negedge; WAIT is high in cycles
    // [ws,we).  Random junk on cmd_* while busy must be ignored.
    task automatic issue(input bit wr, input bit io,
                         input logic [15:0] a, input logic [7:0] d,
                         input int ws, input int we);
        int c;
        bit done;
        c = 0;
        while (!cmd_ready && c < 2000) begin
            @(negedge clk42m);
            c++;
        end
        if (!cmd_ready) begin
            chk("ready_wait", 0, 1);
            return;
        end
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_ioreq   = io;
        cmd_address = a;
        cmd_wdata   = d;
        p_slot_wait = 1'b0;
        sbq.push_back(model(wr, io, a, d, ws, we));
        done = 0;
        for (c = 1; c < 3000 && !done; c++) begin
            @(negedge clk42m);
            if (c >= 2 && cmd_ready) begin
                done = 1;
            end else if ($urandom_range(0, 3) == 0) begin
                cmd_valid   = 1'b1;
                cmd_write   = 1'($urandom);
                cmd_ioreq   = 1'($urandom);
                cmd_address = 16'($urandom);
                cmd_wdata   = 8'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            p_slot_wait = !done && c >= ws && c < we;
        end
        cmd_valid   = 1'b0;
        p_slot_wait = 1'b0;
        if (!done) chk("cycle_done", 0, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_ioreq   = 1'b0;
        cmd_address = 16'd0;
        cmd_wdata   = 8'd0;
        p_slot_wait = 1'b0;
        p_slot_int  = 1'b0;
        #2 reset_n = 1'b0;
        #3;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_strobes",
            {p_slot_sltsl_n, p_slot_mreq_n, p_slot_ioreq_n,
             p_slot_rd_n, p_slot_wr_n, p_slot_m1_n, p_slot_rfsh_n},
            7'h7F);
        chk("rst_addr_data", {p_slot_address, p_slot_data_out}, 0);
        chk("rst_flags", {p_slot_data_oe, rdata_en, timeout}, 0);
        chk("rst_rdata_int", {rdata, int_n}, 1);
        repeat (3) @(negedge clk42m);
        reset_n = 1'b1;
        mon_en  = 1;
        @(negedge clk42m);

        issue(0, 0, 16'h4000, 8'h00, 0, 0);
        issue(1, 1, 16'h0099, 8'h3C, 0, 0);
        issue(0, 0, 16'h4000, 8'h00, 3, 69);
        issue(0, 0, 16'h8123, 8'h00, 1, 1 << 20);
        issue(1, 0, 16'hC001, 8'h77, 1, 1 << 20);

        repeat (40) begin
            int ws, we;
            if ($urandom_range(0, 1) == 0) begin
                ws = 0; we = 0;
            end else begin
                ws = $urandom_range(1, 60);
                we = ws + $urandom_range(1, 80);
            end
            issue(1'($urandom), 1'($urandom), 16'($urandom),
                  8'($urandom), ws, we);
        end

        repeat (4) @(negedge clk42m);
        chk("queue_drained", sbq.size(), 0);

        // Reset in the middle of a memory write (cycle 19, in T2).
        mon_en = 0;
        @(negedge clk42m);
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_ioreq   = 1'b0;
        cmd_address = 16'h5555;
        cmd_wdata   = 8'hC3;
        @(negedge clk42m);
        cmd_valid = 1'b0;
        repeat (18) @(negedge clk42m);
        chk("mid_strobes_low",
            {p_slot_mreq_n, p_slot_wr_n, p_slot_data_oe}, 3'b001);
        #2 reset_n = 1'b0;
        #1;
        chk("async_strobes",
            {p_slot_sltsl_n, p_slot_mreq_n, p_slot_ioreq_n,
             p_slot_rd_n, p_slot_wr_n}, 5'h1F);
        chk("async_oe_ready", {p_slot_data_oe, cmd_ready}, 1);
        chk("async_addr", p_slot_address, 0);
        @(negedge clk42m);
        reset_n = 1'b1;

        // Interrupt passes two flops, inverted.
        @(negedge clk42m);
        p_slot_int = 1'b1;
        @(posedge clk42m); #1;
        chk("int_n_edge1", int_n, 1);
        @(posedge clk42m); #1;
        chk("int_n_edge2", int_n, 0);
        @(negedge clk42m);
        p_slot_int = 1'b0;
        @(posedge clk42m);
        @(posedge clk42m); #1;
        chk("int_n_release", int_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
